// File: rtl/sar_adc_multi.sv
// Multi-channel successive-approximation ADC model with real-valued inputs.
// One code bit is resolved per clock, MSB first. Supports single-shot conversion
// of a selected channel and continuous round-robin scanning.
//
// Optional feature: define SAR_ADC_CLIP_FLAG_EN to add the clip_o output.
//
// Ports:
//   clk       conversion clock, rising edge
//   rst_n     asynchronous active-low reset
//   vin_i     analog channel voltages (real, CHANNELS entries)
//   start_i   conversion request, sampled only while idle
//   scan_i    1 = continuous round-robin scan, 0 = single-shot
//   ch_sel_i  single-shot channel / first scan channel (out of range -> 0)
//   busy_o    high from SAMPLE through DONE
//   valid_o   one-cycle pulse, code_o/ch_out_o carry a fresh result
//   code_o    last completed conversion result
//   ch_out_o  channel that produced code_o
//   clip_o    (SAR_ADC_CLIP_FLAG_EN only) raw sample was outside [0, VREF]
module sar_adc_multi #(
  parameter int unsigned  BITS     = 8,
  parameter int unsigned  CHANNELS = 4,
  parameter real          VREF     = 1.0,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  real             vin_i [CHANNELS],
  input  logic            start_i,
  input  logic            scan_i,
  input  logic [CH_W-1:0] ch_sel_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [BITS-1:0] code_o,
  output logic [CH_W-1:0] ch_out_o
`ifdef SAR_ADC_CLIP_FLAG_EN
  ,
  output logic            clip_o
`endif
);

  localparam int unsigned IdxW = $clog2(BITS);
  localparam real         Lsb  = VREF / real'(2 ** BITS);

  typedef enum logic [1:0] {StIdle, StSample, StConvert, StDone} state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            mode_q, mode_d;
  real             held_q, held_d;
  logic [BITS-1:0] sar_q, sar_d;
  logic [IdxW-1:0] bit_q, bit_d;
  logic [BITS-1:0] code_q, code_d;
  logic [CH_W-1:0] ch_out_q, ch_out_d;
  logic [BITS-1:0] res;
  logic            sel_ok;
  logic [CH_W-1:0] ch_next;
`ifdef SAR_ADC_CLIP_FLAG_EN
  logic            clip_raw_q, clip_raw_d;
  logic            clip_q, clip_d;
`endif

  // NaN fails every comparison, so it is caught by the self-inequality test.
  function automatic real clamp_vref(input real v);
    real r;
    if ((v != v) || (v < 0.0)) r = 0.0;
    else if (v > VREF)         r = VREF;
    else                       r = v;
    return r;
  endfunction

  assign sel_ok  = 32'(ch_sel_i) < CHANNELS;
  assign ch_next = (32'(ch_q) == CHANNELS - 1) ? '0 : ch_q + CH_W'(1);

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mode_d   = mode_q;
    held_d   = held_q;
    sar_d    = sar_q;
    bit_d    = bit_q;
    code_d   = code_q;
    ch_out_d = ch_out_q;
    res      = sar_q;
`ifdef SAR_ADC_CLIP_FLAG_EN
    clip_raw_d = clip_raw_q;
    clip_d     = clip_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          ch_d    = sel_ok ? ch_sel_i : '0;
          mode_d  = scan_i;
          state_d = StSample;
        end
      end
      StSample: begin
        held_d  = clamp_vref(vin_i[ch_q]);
        sar_d   = {1'b1, {(BITS-1){1'b0}}};
        bit_d   = IdxW'(BITS - 1);
        state_d = StConvert;
`ifdef SAR_ADC_CLIP_FLAG_EN
        clip_raw_d = (vin_i[ch_q] < 0.0) || (vin_i[ch_q] > VREF);
`endif
      end
      StConvert: begin
        // Drop the trial bit if the held sample is below the trial level.
        if (!(held_q >= real'(sar_q) * Lsb)) res[bit_q] = 1'b0;
        if (bit_q == '0) begin
          // Result registers load on entry to DONE so valid_o and code_o coincide.
          code_d   = res;
          ch_out_d = ch_q;
          state_d  = StDone;
`ifdef SAR_ADC_CLIP_FLAG_EN
          clip_d   = clip_raw_q;
`endif
        end else begin
          res[bit_q - 1'b1] = 1'b1;
          bit_d             = bit_q - 1'b1;
        end
        sar_d = res;
      end
      StDone: begin
        if (mode_q && scan_i) begin
          ch_d    = ch_next;
          state_d = StSample;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      mode_q   <= 1'b0;
      held_q   <= 0.0;
      sar_q    <= '0;
      bit_q    <= IdxW'(BITS - 1);
      code_q   <= '0;
      ch_out_q <= '0;
`ifdef SAR_ADC_CLIP_FLAG_EN
      clip_raw_q <= 1'b0;
      clip_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mode_q   <= mode_d;
      held_q   <= held_d;
      sar_q    <= sar_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      ch_out_q <= ch_out_d;
`ifdef SAR_ADC_CLIP_FLAG_EN
      clip_raw_q <= clip_raw_d;
      clip_q     <= clip_d;
`endif
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign valid_o  = (state_q == StDone);
  assign code_o   = code_q;
  assign ch_out_o = ch_out_q;
`ifdef SAR_ADC_CLIP_FLAG_EN
  assign clip_o   = clip_q;
`endif

endmodule

// File: tb/tb_sar_adc_multi.sv
// Self-checking bench for sar_adc_multi: directed boundary cases, scan,
// hold isolation, async reset and randomized single-shot conversions against
// an arithmetic reference model. A second instance with CHANNELS=3 exercises
// an out-of-range channel select.
module tb_sar_adc_multi;

  localparam int  BITS = 8;
  localparam int  CH   = 4;
  localparam real VREF = 1.0;
  localparam int  LAT  = BITS + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  real        vin [CH];
  logic       start = 1'b0;
  logic       scan = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  logic       busy, valid;
  logic [7:0] code;
  logic [1:0] ch_out;

  real        vin_b [3];
  logic       start_b = 1'b0;
  logic       scan_b = 1'b0;
  logic [1:0] ch_sel_b = 2'd0;
  logic       busy_b, valid_b;
  logic [7:0] code_b;
  logic [1:0] ch_out_b;
`ifdef SAR_ADC_CLIP_FLAG_EN
  logic       clip, clip_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sar_adc_multi #(.BITS(BITS), .CHANNELS(CH), .VREF(VREF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vin_i    (vin),
    .start_i  (start),
    .scan_i   (scan),
    .ch_sel_i (ch_sel),
    .busy_o   (busy),
    .valid_o  (valid),
    .code_o   (code),
    .ch_out_o (ch_out)
`ifdef SAR_ADC_CLIP_FLAG_EN
    ,
    .clip_o   (clip)
`endif
  );

  sar_adc_multi #(.BITS(BITS), .CHANNELS(3), .VREF(VREF)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .vin_i    (vin_b),
    .start_i  (start_b),
    .scan_i   (scan_b),
    .ch_sel_i (ch_sel_b),
    .busy_o   (busy_b),
    .valid_o  (valid_b),
    .code_o   (code_b),
    .ch_out_o (ch_out_b)
`ifdef SAR_ADC_CLIP_FLAG_EN
    ,
    .clip_o   (clip_b)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Ideal converter: floor(v * 2^BITS / VREF), clamped, NaN -> 0.
  function automatic int model_code(input real v);
    real x;
    if ((v != v) || (v <= 0.0)) return 0;
    if (v >= VREF) return 2 ** BITS - 1;
    x = $floor(v * real'(2 ** BITS) / VREF);
    if (x > real'(2 ** BITS - 1)) return 2 ** BITS - 1;
    return int'(x);
  endfunction

  function automatic int model_clip(input real v);
    return ((v < 0.0) || (v > VREF)) ? 1 : 0;
  endfunction

  // Single-shot conversion. Cycle n counts negedges after the start edge, so
  // an observation at n corresponds to the upcoming rising edge n.
  task automatic run_single(input string tag, input int sel, input int exp_ch,
                            input int step_at, input real step_v, input bit poke);
    real v0;
    int  n, lat, got_code, got_ch, got_clip, busy_ok, exp_code;
    v0       = vin[exp_ch];
    exp_code = model_code(v0);
    lat      = -1;
    got_code = -1;
    got_ch   = -1;
    got_clip = -1;
    busy_ok  = 1;
    n        = 0;
    @(negedge clk);
    start  = 1'b1;
    scan   = 1'b0;
    ch_sel = 2'(sel);
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (n == step_at) vin[exp_ch] = step_v;
      if (poke && n == 4) begin
        start  = 1'b1;
        ch_sel = 2'(sel + 1);
      end
      if (poke && n == 5) start = 1'b0;
      if (!busy) busy_ok = 0;
      if (valid) begin
        lat      = n;
        got_code = int'(code);
        got_ch   = int'(ch_out);
`ifdef SAR_ADC_CLIP_FLAG_EN
        got_clip = int'(clip);
`endif
      end
    end
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".code"}, got_code, exp_code);
    check({tag, ".ch_out"}, got_ch, exp_ch);
    check({tag, ".busy"}, busy_ok, 1);
`ifdef SAR_ADC_CLIP_FLAG_EN
    check({tag, ".clip"}, got_clip, model_clip(v0));
`endif
    @(negedge clk);
    check({tag, ".idle"}, busy, 0);
    check({tag, ".hold"}, code, exp_code);
  endtask

  initial begin
    int n, got, last, exp_ch;
    for (int i = 0; i < CH; i++) vin[i] = 0.0;
    for (int i = 0; i < 3; i++) vin_b[i] = 0.0;

    // Reset state
    @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.valid", valid, 0);
    check("rst.code", code, 0);
    check("rst.ch_out", ch_out, 0);
`ifdef SAR_ADC_CLIP_FLAG_EN
    check("rst.clip", clip, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-scale single shot on channel 2
    vin[2] = 0.5;
    run_single("mid", 2, 2, 0, 0.0, 1'b0);

    // Boundaries on channel 0
    vin[0] = -0.3;
    run_single("neg", 0, 0, 0, 0.0, 1'b0);
    vin[0] = 1.7;
    run_single("over", 0, 0, 0, 0.0, 1'b0);
    vin[0] = VREF - 1e-9;
    run_single("near_fs", 0, 0, 0, 0.0, 1'b0);
    vin[0] = $bitstoreal(64'h7FF8_0000_0000_0000);
    run_single("nan", 0, 0, 0, 0.0, 1'b0);

    // Hold isolation: input steps during CONVERT, then the new value converts
    vin[1] = 0.25;
    run_single("hold", 1, 1, 3, 0.9, 1'b0);
    run_single("hold2", 1, 1, 0, 0.0, 1'b0);

    // start while busy is ignored
    vin[2] = 0.5;
    vin[3] = 0.75;
    run_single("busy_start", 2, 2, 0, 0.0, 1'b1);

    // Scan from channel 3, five results, then end scan
    vin[0] = 0.1;
    vin[1] = 0.2;
    vin[2] = 0.3;
    vin[3] = 0.4;
    @(negedge clk);
    start  = 1'b1;
    scan   = 1'b1;
    ch_sel = 2'd3;
    n      = 0;
    got    = 0;
    last   = 0;
    while (got < 5 && n < 120) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (valid) begin
        exp_ch = (3 + got) % CH;
        check("scan.ch_out", ch_out, exp_ch);
        check("scan.code", code, model_code(vin[exp_ch]));
        check("scan.period", n - last, LAT);
        last = n;
        got++;
        if (got == 5) scan = 1'b0;
      end
    end
    check("scan.count", got, 5);
    @(negedge clk);
    check("scan.stop", busy, 0);

    // Asynchronous reset mid-CONVERT
    vin[1] = 0.9;
    @(negedge clk);
    start  = 1'b1;
    ch_sel = 2'd1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.valid", valid, 0);
    check("arst.code", code, 0);
    check("arst.ch_out", ch_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_single("post_rst", 1, 1, 0, 0.0, 1'b0);

    // Randomized single shots
    for (int t = 0; t < 20; t++) begin
      int c;
      for (int i = 0; i < CH; i++)
        vin[i] = -0.2 + 1.4 * real'($urandom_range(0, 100000)) / 100000.0;
      c = int'($urandom_range(0, CH - 1));
      run_single($sformatf("rand%0d", t), c, c, 0, 0.0, 1'b0);
    end

    // Out-of-range select on a 3-channel instance converts channel 0
    vin_b[0] = 0.6;
    vin_b[1] = 0.1;
    vin_b[2] = 0.2;
    @(negedge clk);
    start_b  = 1'b1;
    ch_sel_b = 2'd3;
    n        = 0;
    got      = -1;
    while (n < 40 && got < 0) begin
      @(negedge clk);
      n++;
      if (n == 1) start_b = 1'b0;
      if (valid_b) begin
        got = n;
        check("oor.ch_out", ch_out_b, 0);
        check("oor.code", code_b, model_code(0.6));
`ifdef SAR_ADC_CLIP_FLAG_EN
        check("oor.clip", clip_b, 0);
`endif
      end
    end
    check("oor.latency", got, LAT);
    @(negedge clk);
    check("oor.idle", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
